// File: rtl/line_buffer3.sv
// Two-line buffer feeding a 3x3 window: emits lines y-2, y-1, y per column with coordinates.
// Latency: one cycle from an accepted pixel to shift_en with its column data.
// No backpressure: one pixel per cycle sustained; idle cycles simply hold the outputs.
module line_buffer3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             pixel_valid,
  input  logic             frame_start,
  output logic [PIX_W-1:0] pixel_out_row_1,
  output logic [PIX_W-1:0] pixel_out_row_2,
  output logic [PIX_W-1:0] pixel_out_row_3,
  output logic             shift_en,
  output logic             window_valid,
  output logic [COL_W-1:0] out_col,
  output logic [ROW_W-1:0] out_row,
  output logic             frame_done
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  // Line memories: line_a holds line y-1, line_b holds line y-2. Never reset;
  // stale contents are hidden by the row gating on the first two lines.
  logic [PIX_W-1:0] r_line_a [IMG_WIDTH];
  logic [PIX_W-1:0] r_line_b [IMG_WIDTH];

  // Raster position of the next pixel to arrive.
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  // Output registers.
  logic [PIX_W-1:0] r_row_1;
  logic [PIX_W-1:0] r_row_2;
  logic [PIX_W-1:0] r_row_3;
  logic             r_shift_en;
  logic             r_window_valid;
  logic [COL_W-1:0] r_out_col;
  logic [ROW_W-1:0] r_out_row;
  logic             r_frame_done;

  // Position actually used for this pixel: a qualified frame_start forces (0,0).
  logic             w_restart;
  logic [COL_W-1:0] w_cur_col;
  logic [ROW_W-1:0] w_cur_row;
  logic             w_last_col;
  logic             w_last_row;
  logic [COL_W-1:0] w_next_col;
  logic [ROW_W-1:0] w_next_row;
  logic [AW-1:0]    w_addr;
  logic [PIX_W-1:0] w_rd_a;
  logic [PIX_W-1:0] w_rd_b;
  logic             w_gate_row_2;
  logic             w_gate_row_1;
  logic             w_window_full;

  assign w_restart  = pixel_valid && frame_start;
  assign w_cur_col  = w_restart ? '0 : r_col;
  assign w_cur_row  = w_restart ? '0 : r_row;
  assign w_last_col = (w_cur_col == COL_W'(IMG_WIDTH - 1));
  assign w_last_row = (w_cur_row == ROW_W'(IMG_HEIGHT - 1));
  assign w_addr     = w_cur_col[AW-1:0];

  // Memory reads happen before the same-edge write, so these are the old lines.
  assign w_rd_a = r_line_a[w_addr];
  assign w_rd_b = r_line_b[w_addr];

  // Lines above the top of the current frame do not exist yet.
  assign w_gate_row_2  = (w_cur_row == '0);
  assign w_gate_row_1  = (w_cur_row < ROW_W'(2));
  assign w_window_full = (w_cur_row >= ROW_W'(2)) && (w_cur_col >= COL_W'(2));

  // Next raster position: advance column, wrap into the next row, wrap the frame.
  always_comb begin
    w_next_col = w_cur_col + COL_W'(1);
    w_next_row = w_cur_row;
    if (w_last_col) begin
      w_next_col = '0;
      w_next_row = w_last_row ? '0 : (w_cur_row + ROW_W'(1));
    end
  end

  // Coordinate counters advance only on accepted pixels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pixel_valid) begin
      r_col <= w_next_col;
      r_row <= w_next_row;
    end
  end

  // Shift the column down one line: y-1 moves to y-2, the new pixel becomes y-1.
  always_ff @(posedge clock) begin
    if (pixel_valid) begin
      r_line_b[w_addr] <= w_rd_a;
      r_line_a[w_addr] <= pixel_in;
    end
  end

  // Register the gated column, its coordinates and the per-pixel strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_row_1        <= '0;
      r_row_2        <= '0;
      r_row_3        <= '0;
      r_shift_en     <= 1'b0;
      r_window_valid <= 1'b0;
      r_out_col      <= '0;
      r_out_row      <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      r_shift_en     <= pixel_valid;
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      if (pixel_valid) begin
        r_row_3        <= pixel_in;
        r_row_2        <= w_gate_row_2 ? '0 : w_rd_a;
        r_row_1        <= w_gate_row_1 ? '0 : w_rd_b;
        r_window_valid <= w_window_full;
        r_frame_done   <= w_last_col && w_last_row;
        r_out_col      <= w_cur_col;
        r_out_row      <= w_cur_row;
      end
    end
  end

  assign pixel_out_row_1 = r_row_1;
  assign pixel_out_row_2 = r_row_2;
  assign pixel_out_row_3 = r_row_3;
  assign shift_en        = r_shift_en;
  assign window_valid    = r_window_valid;
  assign out_col         = r_out_col;
  assign out_row         = r_out_row;
  assign frame_done      = r_frame_done;

endmodule

// File: doc/line_buffer3.md
Name: line_buffer3

Overview:
- Converts a raster-order pixel stream into three vertically aligned pixels per column: lines y-2, y-1 and y.
- Drives the 3x3 window shift register directly downstream.
- Holds two full image lines in internal memory and produces that stage's shift enable.
- Tracks image coordinates and flags when the 3x3 window is fully populated, so the edge kernel can qualify its results.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=3)
- IMG_HEIGHT, 480, lines per frame (>=3)
- PIX_W, 8, bits per pixel
- COL_W, 10, col counter width, >= clog2(IMG_WIDTH)
- ROW_W, 9, row counter width, >= clog2(IMG_HEIGHT)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pixel_in  in  PIX_W  incoming raster pixel
- pixel_valid  in  1  pixel_in valid this cycle; no backpressure
- frame_start  in  1  qualifies pixel_in as pixel (0,0) of a new frame; ignored unless pixel_valid
- pixel_out_row_1  out  PIX_W  pixel from line y-2 (top of window)
- pixel_out_row_2  out  PIX_W  pixel from line y-1
- pixel_out_row_3  out  PIX_W  pixel from line y (current)
- shift_en  out  1  one-cycle pulse; row outputs are new, and downstream must shift
- window_valid  out  1  with shift_en: 3x3 window downstream is fully real data
- out_col  out  COL_W  column of pixel_out_row_3
- out_row  out  ROW_W  row of pixel_out_row_3
- frame_done  out  1  one-cycle pulse with shift_en for the last pixel of the frame

Behaviour:
- Reset: asynchronous, active-high, on clock. All outputs go to 0 and internal col/row counters go to 0. Line memories are not reset; stale data is masked by the row gating below.
- Storage: two arrays, line_a (y-1) and line_b (y-2), each IMG_WIDTH x PIX_W.
- Accepted pixel: pixel_valid=1. At counter position (c,r), in one clock edge:
  - Outputs register: row_3<=pixel_in, row_2<=line_a[c], row_1<=line_b[c].
  - Memories update: line_b[c]<=line_a[c], line_a[c]<=pixel_in.
  - Read-before-write at the same address.
- Latency: exactly 1 cycle from accepted pixel to shift_en=1 with its data.
- Row gating (current frame only):
  - r=0: row_2 and row_1 forced to 0.
  - r=1: row_1 forced to 0.
- shift_en: 1 for exactly the cycle after each accepted pixel, otherwise 0. Row outputs hold their values when shift_en=0.
- window_valid: 1 with shift_en when r>=2 and c>=2. Otherwise 0, including when shift_en=0.
- out_col/out_row: registered (c,r) of the accepted pixel.
- Counters: c increments per accepted pixel. At c=IMG_WIDTH-1, c wraps to 0 and r increments. At (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0 and frame_done pulses with that pixel's shift_en.
- frame_start with pixel_valid: that pixel is treated as (0,0) regardless of the counters (mid-frame restart). Counters continue from (1,0), and row gating restarts.
- pixel_valid=0 gaps: no counter, memory or output-data change. Gaps of any length are allowed, including mid-line.
- Throughput: one pixel per cycle sustained, no stalls.
- Reset mid-line: counters return to 0. The next frame must begin with frame_start; without it, the next pixel is treated as (0,0) anyway.

Test Plan:
- Reset: assert reset mid-stream → all outputs 0 immediately, asynchronously. Next accepted pixel reports out_col=0, out_row=0.
- Full frame, IMG_WIDTH=4, IMG_HEIGHT=4, pixel=16*r+c, continuous valid, frame_start on the first pixel:
  - At pixel (2,2) → row_1=0x02, row_2=0x12, row_3=0x22, window_valid=1.
  - At (1,2) → window_valid=0.
  - At (3,3) → frame_done=1.
- Row gating: pixels of row 0 → row_1=row_2=0. Row 1, col 3 → row_1=0, row_2=0x03, row_3=0x13.
- Valid gaps: insert 3 idle cycles between each pixel → shift_en pulses once per pixel, data identical to the continuous run, outputs held during gaps.
- Back-to-back frames:
  - Second frame with pixels 0x80+16*r+c → row (0,*) outputs have row_1=row_2=0, with no leakage of frame 1.
  - At (2,2) → 0x82/0x92/0xA2.
- Mid-frame frame_start at (1,1) → that pixel reported as (0,0), row gating zeros row_1 and row_2, window_valid=0 until new (2,2).
